// File: rtl/tl_host_requester_pkg.sv
// Shared TileLink-UL channel types, opcodes and default widths for the host-side
// MPU link.
package tl_host_requester_pkg;

    localparam int TL_SRC_BITS = 2;
    localparam int TL_ADDR_W   = 32;
    localparam int TL_DATA_W   = 32;
    localparam int TL_MASK_W   = TL_DATA_W / 8;

    // A-channel opcodes
    localparam logic [2:0] TL_GET         = 3'd4;
    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;

    // D-channel opcodes
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [2:0]             param;
        logic [1:0]             size;
        logic [TL_SRC_BITS-1:0] source;
        logic [TL_ADDR_W-1:0]   address;
        logic [TL_MASK_W-1:0]   mask;
        logic [TL_DATA_W-1:0]   data;
    } tl_a_channel;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [TL_SRC_BITS-1:0] source;
        logic [TL_DATA_W-1:0]   data;
        logic                   denied;
    } tl_d_channel;

    // Builds the A beat for a local command. Transfers are always one 4-byte word.
    function automatic tl_a_channel encode_a(
        input logic                   write,
        input logic [TL_ADDR_W-1:0]   addr,
        input logic [TL_DATA_W-1:0]   wdata,
        input logic [TL_MASK_W-1:0]   mask,
        input logic [TL_SRC_BITS-1:0] source
    );
        tl_a_channel a;
        a         = '0;
        a.param   = 3'd0;
        a.size    = 2'd2;
        a.source  = source;
        a.address = addr;
        if (!write) begin
            a.opcode = TL_GET;
            a.mask   = '1;
            a.data   = '0;
        end else begin
            a.opcode = (mask == '1) ? TL_PUT_FULL : TL_PUT_PARTIAL;
            a.mask   = mask;
            a.data   = wdata;
        end
        return a;
    endfunction

endpackage

// File: rtl/tl_host_requester_src_alloc.sv
// Source-ID pool: busy bitmap, lowest-free allocation and outstanding count.
module tl_host_requester_src_alloc
    import tl_host_requester_pkg::*;
#(
    parameter int SRC_BITS = TL_SRC_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc,
    input  logic                       free,
    input  logic [SRC_BITS-1:0]        free_id,
    output logic                       any_free,
    output logic [SRC_BITS-1:0]        alloc_id,
    output logic [(1<<SRC_BITS)-1:0]   busy,
    output logic [SRC_BITS:0]          outstanding
);

    localparam int N = 1 << SRC_BITS;

    logic [N-1:0] busy_next;

    // Scan from the top so the lowest free index wins.
    always_comb begin
        any_free = 1'b0;
        alloc_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_free = 1'b1;
                alloc_id = SRC_BITS'(i);
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < N; i++) begin
            outstanding = outstanding + (SRC_BITS+1)'(busy[i]);
        end
    end

    // alloc_id comes from the pre-edge bitmap, so it can never equal a busy free_id.
    always_comb begin
        busy_next = busy;
        if (free) begin
            busy_next[free_id] = 1'b0;
        end
        if (alloc) begin
            busy_next[alloc_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/tl_host_requester.sv
// TileLink-UL initiator for the host side of the MPU link: tags local commands
// with free source IDs, issues A beats and returns matched D responses.
module tl_host_requester
    import tl_host_requester_pkg::*;
#(
    parameter int SRC_BITS = TL_SRC_BITS,
    parameter int ADDR_W   = TL_ADDR_W,
    parameter int DATA_W   = TL_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_mask,
    output logic                  a_valid,
    input  logic                  a_ready,
    output tl_a_channel           a_out,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  tl_d_channel           d_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [SRC_BITS-1:0]   rsp_source,
    output logic                  rsp_write,
    output logic                  rsp_error,
    output logic [SRC_BITS:0]     outstanding,
    output logic                  err_unexpected,
    input  logic                  drain,
    output logic                  idle
);

    localparam int N = 1 << SRC_BITS;

    logic                any_free;
    logic [SRC_BITS-1:0] alloc_id;
    logic [N-1:0]        busy;
    logic [N-1:0]        is_write;
    logic                cmd_fire;
    logic                d_fire;
    logic                d_hit;

    assign cmd_ready = !drain && any_free && (!a_valid || a_ready);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign d_ready   = !rsp_valid || rsp_ready;
    assign d_fire    = d_valid && d_ready;
    assign d_hit     = d_fire && busy[d_in.source];
    assign idle      = (outstanding == '0) && !a_valid && !rsp_valid;

    tl_host_requester_src_alloc #(
        .SRC_BITS (SRC_BITS)
    ) u_src_alloc (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc       (cmd_fire),
        .free        (d_hit),
        .free_id     (d_in.source),
        .any_free    (any_free),
        .alloc_id    (alloc_id),
        .busy        (busy),
        .outstanding (outstanding)
    );

    // A channel: hold the beat until a_ready; a same-cycle accept reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_out   <= '0;
        end else if (cmd_fire) begin
            a_valid <= 1'b1;
            a_out   <= encode_a(cmd_write, cmd_addr, cmd_wdata, cmd_mask, alloc_id);
        end else if (a_ready) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write <= '0;
        end else if (cmd_fire) begin
            is_write[alloc_id] <= cmd_write;
        end
    end

    // Response skid register; d_ready guarantees it is empty or draining on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_source <= '0;
            rsp_write  <= 1'b0;
            rsp_error  <= 1'b0;
        end else if (d_hit) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= (d_in.opcode == TL_ACCESS_ACK_DATA) ? d_in.data : '0;
            rsp_source <= d_in.source;
            rsp_write  <= is_write[d_in.source];
            rsp_error  <= d_in.denied;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexpected <= 1'b0;
        end else if (d_fire && !busy[d_in.source]) begin
            err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tl_host_requester.sv
// Directed bench for tl_host_requester: table of single transactions plus
// hand-written multi-cycle sequences.
module tb_tl_host_requester;
    import tl_host_requester_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_mask;
    logic        a_valid;
    logic        a_ready;
    tl_a_channel a_out;
    logic        d_valid;
    logic        d_ready;
    tl_d_channel d_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_source;
    logic        rsp_write;
    logic        rsp_error;
    logic [2:0]  outstanding;
    logic        err_unexpected;
    logic        drain;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    tl_host_requester dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_mask       (cmd_mask),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_out          (a_out),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .d_in           (d_in),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_source     (rsp_source),
        .rsp_write      (rsp_write),
        .rsp_error      (rsp_error),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected),
        .drain          (drain),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [2:0]  d_op;
        logic [31:0] d_data;
        logic        d_den;
        logic [2:0]  e_op;
        logic [3:0]  e_mask;
        logic [31:0] e_adata;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d_beat(input logic [1:0] src, input logic [2:0] op, input logic [31:0] data);
        d_in.source = src;
        d_in.opcode = op;
        d_in.data   = data;
        d_in.denied = 1'b0;
    endtask

    initial begin
        logic [1:0] order [4];
        order = '{2'd3, 2'd0, 2'd1, 2'd2};

        //               wr    addr          wdata         mask   d_op  d_data        den   e_op  e_mask e_adata       e_rdata       e_err
        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0000_1234, 4'h0, 3'd1, 32'hDEAD_BEEF, 1'b0, 3'd4, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'hF, 3'd0, 32'h0000_0055, 1'b0, 3'd0, 4'hF, 32'hCAFE_F00D, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 32'h0000_0204, 32'h1122_3344, 4'h3, 3'd0, 32'h0,         1'b0, 3'd1, 4'h3, 32'h1122_3344, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 32'h0000_0208, 32'h8765_4321, 4'h0, 3'd0, 32'h0,         1'b1, 3'd1, 4'h0, 32'h8765_4321, 32'h0,        1'b1};
        vecs[4] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hA, 3'd1, 32'h0BAD_0BAD, 1'b1, 3'd4, 4'hF, 32'h0,        32'h0BAD_0BAD, 1'b1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_mask  = '0;
        a_ready   = 1'b1;
        d_valid   = 1'b0;
        d_in      = '0;
        rsp_ready = 1'b1;
        drain     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        chk("reset_a_valid", a_valid, 0);
        chk("reset_a_out", a_out, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_outstanding", outstanding, 0);
        chk("reset_err", err_unexpected, 0);
        chk("reset_d_ready", d_ready, 1);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_idle", idle, 1);
        drain = 1'b1;
        #1 chk("drain_blocks_cmd", cmd_ready, 0);
        drain = 1'b0;

        // Single transactions, each returning to idle
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_write = vecs[i].wr;
            cmd_addr  = vecs[i].addr;
            cmd_wdata = vecs[i].wdata;
            cmd_mask  = vecs[i].mask;
            #1 chk("vec_cmd_ready", cmd_ready, 1);
            step();
            cmd_valid = 1'b0;
            chk("vec_a_valid", a_valid, 1);
            chk("vec_opcode", a_out.opcode, vecs[i].e_op);
            chk("vec_mask", a_out.mask, vecs[i].e_mask);
            chk("vec_adata", a_out.data, vecs[i].e_adata);
            chk("vec_addr", a_out.address, vecs[i].addr);
            chk("vec_source", a_out.source, 0);
            chk("vec_size", a_out.size, 2);
            chk("vec_param", a_out.param, 0);
            chk("vec_outstanding1", outstanding, 1);
            step();
            chk("vec_a_valid_clr", a_valid, 0);
            d_valid = 1'b1;
            d_beat(2'd0, vecs[i].d_op, vecs[i].d_data);
            d_in.denied = vecs[i].d_den;
            #1 chk("vec_d_ready", d_ready, 1);
            step();
            d_valid = 1'b0;
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_data", rsp_data, vecs[i].e_rdata);
            chk("vec_rsp_source", rsp_source, 0);
            chk("vec_rsp_write", rsp_write, vecs[i].wr);
            chk("vec_rsp_error", rsp_error, vecs[i].e_err);
            chk("vec_outstanding0", outstanding, 0);
            step();
            chk("vec_rsp_clr", rsp_valid, 0);
            chk("vec_idle", idle, 1);
        end

        // Back-to-back writes: full mask then partial
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'h0101_0101;
        cmd_mask  = 4'hF;
        step();
        chk("wr0_opcode", a_out.opcode, 0);
        chk("wr0_source", a_out.source, 0);
        cmd_mask  = 4'h3;
        #1 chk("wr1_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("wr1_opcode", a_out.opcode, 1);
        chk("wr1_source", a_out.source, 1);
        chk("wr_outstanding", outstanding, 2);
        step();
        for (int s = 0; s < 2; s++) begin
            d_valid = 1'b1;
            d_beat(2'(s), TL_ACCESS_ACK, 32'hFFFF_FFFF);
            step();
            chk("wr_rsp_source", rsp_source, s);
            chk("wr_rsp_write", rsp_write, 1);
            chk("wr_rsp_data", rsp_data, 0);
        end
        d_valid = 1'b0;
        step();
        chk("wr_idle", idle, 1);

        // Pool exhaustion and reuse of a freed source
        cmd_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 32'h0000_1000 + 32'(4 * i);
            #1 chk("pool_cmd_ready", cmd_ready, 1);
            step();
            chk("pool_source", a_out.source, i);
            chk("pool_a_valid", a_valid, 1);
        end
        #1 chk("pool_full_ready", cmd_ready, 0);
        chk("pool_outstanding4", outstanding, 4);
        cmd_valid = 1'b0;
        d_valid   = 1'b1;
        d_beat(2'd2, TL_ACCESS_ACK_DATA, 32'h0000_0022);
        step();
        d_valid = 1'b0;
        chk("pool_rsp_source", rsp_source, 2);
        chk("pool_rsp_data", rsp_data, 32'h22);
        chk("pool_outstanding3", outstanding, 3);
        cmd_valid = 1'b1;
        #1 chk("pool_reuse_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("pool_reuse_source", a_out.source, 2);
        chk("pool_outstanding_again", outstanding, 4);
        step();

        // Out-of-order responses with the local side stalled for 3 cycles
        rsp_ready = 1'b0;
        d_valid   = 1'b1;
        d_beat(order[0], TL_ACCESS_ACK_DATA, 32'h30 + 32'(order[0]));
        #1 chk("ooo_first_d_ready", d_ready, 1);
        step();
        chk("ooo_first_rsp", rsp_source, 3);
        d_beat(order[1], TL_ACCESS_ACK_DATA, 32'h30 + 32'(order[1]));
        for (int k = 0; k < 3; k++) begin
            #1 chk("ooo_stall_d_ready", d_ready, 0);
            step();
            chk("ooo_hold_source", rsp_source, 3);
            chk("ooo_hold_data", rsp_data, 32'h33);
        end
        rsp_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            d_beat(order[j], TL_ACCESS_ACK_DATA, 32'h30 + 32'(order[j]));
            #1 chk("ooo_d_ready", d_ready, 1);
            step();
            chk("ooo_rsp_valid", rsp_valid, 1);
            chk("ooo_rsp_source", rsp_source, order[j]);
            chk("ooo_rsp_data", rsp_data, 32'h30 + 32'(order[j]));
            chk("ooo_rsp_write", rsp_write, 0);
        end
        d_valid = 1'b0;
        step();
        chk("ooo_rsp_clr", rsp_valid, 0);
        chk("ooo_outstanding0", outstanding, 0);
        chk("ooo_idle", idle, 1);
        chk("ooo_no_err", err_unexpected, 0);

        // D beat for a source that is not busy
        d_valid = 1'b1;
        d_beat(2'd1, TL_ACCESS_ACK, 32'h0);
        step();
        d_valid = 1'b0;
        chk("unexp_err", err_unexpected, 1);
        chk("unexp_no_rsp", rsp_valid, 0);
        chk("unexp_outstanding", outstanding, 0);
        step();
        chk("unexp_sticky", err_unexpected, 1);

        // A channel backpressure for 5 cycles
        a_ready   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0300;
        cmd_wdata = 32'hA5A5_A5A5;
        cmd_mask  = 4'hF;
        step();
        cmd_addr  = 32'h0000_0400;
        cmd_wdata = 32'h5A5A_5A5A;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_a_valid", a_valid, 1);
            chk("bp_addr", a_out.address, 32'h300);
            chk("bp_data", a_out.data, 32'hA5A5_A5A5);
            chk("bp_source", a_out.source, 0);
            step();
        end
        a_ready = 1'b1;
        #1 chk("bp_release_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("bp_next_addr", a_out.address, 32'h400);
        chk("bp_next_source", a_out.source, 1);
        chk("bp_next_data", a_out.data, 32'h5A5A_5A5A);
        step();
        chk("bp_a_valid_clr", a_valid, 0);
        chk("bp_outstanding2", outstanding, 2);

        // Reset with two transactions outstanding
        rst_n = 1'b0;
        #1;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_source", rsp_source, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexpected, 0);
        chk("rst_idle", idle, 1);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_d_ready", d_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // Stale response for a source issued before reset
        d_valid = 1'b1;
        d_beat(2'd0, TL_ACCESS_ACK, 32'h0);
        step();
        d_valid = 1'b0;
        chk("stale_err", err_unexpected, 1);
        chk("stale_no_rsp", rsp_valid, 0);
        chk("stale_outstanding", outstanding, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
